// File: rtl/ra_2r1w_32x32_sdr_ram.sv
// ra_2r1w_32x32_sdr_ram: 32x32 register array, two registered read ports, one write port, strobe clear.
// Define RA_2R1W_RESET_ARRAY_EN to make reset also clear the array.
module ra_2r1w_32x32_sdr_ram (
  input  logic        clk,
  input  logic        reset,
  input  logic        strobe,
  input  logic        rd_enb_0,
  input  logic [4:0]  rd_adr_0,
  output logic [31:0] rd_dat_0,
  input  logic        rd_enb_1,
  input  logic [4:0]  rd_adr_1,
  output logic [31:0] rd_dat_1,
  input  logic        wr_enb_0,
  input  logic [4:0]  wr_adr_0,
  input  logic [31:0] wr_dat_0
);
  logic [31:0] mem [0:31];
`ifdef RA_2R1W_RESET_ARRAY_EN
  always_ff @(posedge clk or posedge reset)
    if (reset)
      for (int i = 0; i < 32; i++) mem[i] <= '0;
    else if (strobe)
      for (int i = 0; i < 32; i++) mem[i] <= '0;
    else if (wr_enb_0)
      mem[wr_adr_0] <= wr_dat_0;
`else
  // No array reset, but a write or clear coinciding with reset is still dropped
  always_ff @(posedge clk)
    if (!reset) begin
      if (strobe)
        for (int i = 0; i < 32; i++) mem[i] <= '0;
      else if (wr_enb_0)
        mem[wr_adr_0] <= wr_dat_0;
    end
`endif
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      rd_dat_0 <= '0;
      rd_dat_1 <= '0;
    end else begin
      if (rd_enb_0) rd_dat_0 <= mem[rd_adr_0];
      if (rd_enb_1) rd_dat_1 <= mem[rd_adr_1];
    end
endmodule

// File: tb/tb_ra_2r1w_32x32_sdr_ram.sv
// tb_ra_2r1w_32x32_sdr_ram: directed self-checking bench for ra_2r1w_32x32_sdr_ram.
module tb_ra_2r1w_32x32_sdr_ram;
  logic        clk = 0;
  logic        reset = 1;
  logic        strobe = 0;
  logic        rd_enb_0 = 0, rd_enb_1 = 0, wr_enb_0 = 0;
  logic [4:0]  rd_adr_0 = 0, rd_adr_1 = 0, wr_adr_0 = 0;
  logic [31:0] wr_dat_0 = 0;
  logic [31:0] rd_dat_0, rd_dat_1;
  int checks = 0;
  int failures = 0;
  ra_2r1w_32x32_sdr_ram dut (
    .clk(clk), .reset(reset), .strobe(strobe),
    .rd_enb_0(rd_enb_0), .rd_adr_0(rd_adr_0), .rd_dat_0(rd_dat_0),
    .rd_enb_1(rd_enb_1), .rd_adr_1(rd_adr_1), .rd_dat_1(rd_dat_1),
    .wr_enb_0(wr_enb_0), .wr_adr_0(wr_adr_0), .wr_dat_0(wr_dat_0)
  );
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%08h exp=%08h", tag, got, exp);
    end
  endtask
  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    wr_enb_0 = 1; wr_adr_0 = a; wr_dat_0 = d;
    tick();
    wr_enb_0 = 0;
  endtask
  initial begin
    #2;
    tick();
    tick();
    chk("reset_rd0", rd_dat_0, 32'h0);
    chk("reset_rd1", rd_dat_1, 32'h0);
    reset = 0;
    rd_enb_0 = 1; rd_enb_1 = 1; rd_adr_0 = 3; rd_adr_1 = 3;
    tick();
    rd_enb_0 = 0; rd_enb_1 = 0;
`ifdef RA_2R1W_RESET_ARRAY_EN
    chk("post_reset_a3_p0", rd_dat_0, 32'h0);
    chk("post_reset_a3_p1", rd_dat_1, 32'h0);
`endif
    wr(5'd1, 32'h0000AAAA);
    rd_enb_0 = 1; rd_adr_0 = 1;
    tick();
    rd_enb_0 = 0;
    chk("basic_a1_p0", rd_dat_0, 32'h0000AAAA);
    wr(5'd8, 32'h00000008);
    rd_enb_1 = 1; rd_adr_1 = 8;
    tick();
    rd_enb_1 = 0;
    chk("basic_a8_p1", rd_dat_1, 32'h00000008);
    chk("basic_p0_hold", rd_dat_0, 32'h0000AAAA);
    wr(5'd31, 32'hDEADBEEF);
    wr(5'd0, 32'h12345678);
    rd_enb_0 = 1; rd_adr_0 = 31; rd_enb_1 = 1; rd_adr_1 = 0;
    tick();
    rd_enb_0 = 0; rd_enb_1 = 0; rd_adr_0 = 1; rd_adr_1 = 8;
    chk("dual_a31_p0", rd_dat_0, 32'hDEADBEEF);
    chk("dual_a0_p1", rd_dat_1, 32'h12345678);
    tick();
    tick();
    chk("hold_p0", rd_dat_0, 32'hDEADBEEF);
    chk("hold_p1", rd_dat_1, 32'h12345678);
    rd_enb_0 = 1; rd_enb_1 = 1; rd_adr_0 = 31; rd_adr_1 = 31;
    tick();
    rd_enb_0 = 0; rd_enb_1 = 0;
    chk("same_adr_p0", rd_dat_0, 32'hDEADBEEF);
    chk("same_adr_p1", rd_dat_1, 32'hDEADBEEF);
    wr(5'd5, 32'h11111111);
    wr_enb_0 = 1; wr_adr_0 = 5; wr_dat_0 = 32'h22222222;
    rd_enb_0 = 1; rd_adr_0 = 5;
    tick();
    wr_enb_0 = 0;
    chk("rdw_old", rd_dat_0, 32'h11111111);
    tick();
    rd_enb_0 = 0;
    chk("rdw_new", rd_dat_0, 32'h22222222);
    for (int i = 0; i < 32; i++) wr(5'(i), 32'h10000001 + 32'(i) * 3);
    rd_enb_0 = 1; rd_adr_0 = 2;
    tick();
    chk("fill_a2", rd_dat_0, 32'h10000007);
    strobe = 1; wr_enb_0 = 1; wr_adr_0 = 2; wr_dat_0 = 32'hFFFFFFFF;
    rd_enb_1 = 1; rd_adr_1 = 30; rd_adr_0 = 2;
    tick();
    strobe = 0; wr_enb_0 = 0;
    chk("strobe_preclear_p0", rd_dat_0, 32'h10000007);
    chk("strobe_preclear_p1", rd_dat_1, 32'h10000001 + 32'd90);
    for (int i = 0; i < 32; i++) begin
      rd_adr_0 = 5'(i); rd_adr_1 = 5'(31 - i);
      tick();
      chk("clr_p0", rd_dat_0, 32'h0);
      chk("clr_p1", rd_dat_1, 32'h0);
    end
    rd_enb_0 = 0; rd_enb_1 = 0;
    wr(5'd31, 32'hDEADBEEF);
    rd_enb_0 = 1; rd_adr_0 = 31;
    tick();
    rd_enb_0 = 0;
    chk("pre_async_p0", rd_dat_0, 32'hDEADBEEF);
    #2;
    reset = 1;
    #1;
    chk("async_reset_p0", rd_dat_0, 32'h0);
    chk("async_reset_p1", rd_dat_1, 32'h0);
    wr_enb_0 = 1; wr_adr_0 = 7; wr_dat_0 = 32'h55555555;
    tick();
    wr_enb_0 = 0;
    reset = 0;
    rd_enb_0 = 1; rd_adr_0 = 7;
    tick();
    rd_enb_0 = 0;
    chk("reset_aborts_write", rd_dat_0, 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
